// File: rtl/sequence_generator.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first,
// with repeat count, inter-repeat gap, and start/busy/done/err handshake.
module sequence_generator #(
  parameter int WIDTH = 16,
  parameter int LW    = 5,
  parameter int RW    = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [RW-1:0]    rpt,
  input  logic             abort,
  output logic             d,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP_S,
    DONE
  } state_e;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    bit_q, bit_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             d_q, d_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic len_ok;
  logic last_bit;

  // Bit select by mask so every pattern bit stays in use.
  function automatic logic pick(
    input logic [WIDTH-1:0] p,
    input logic [LW-1:0]    i
  );
    return |(p & (ONE << i));
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    bit_d   = bit_q;
    rpt_d   = rpt_q;
    gap_d   = gap_q;
    d_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    len_ok   = (len != '0) && (len <= LEN_MAX);
    last_bit = (bit_q == '0);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_d   = pattern;
            len_d   = len;
            rpt_d   = rpt;
            bit_d   = len - 1'b1;
            state_d = SHIFT;
            d_d     = pick(pattern, len - 1'b1);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (!last_bit) begin
          bit_d   = bit_q - 1'b1;
          d_d     = pick(pat_q, bit_q - 1'b1);
          valid_d = 1'b1;
        end else if (rpt_q != '0) begin
          rpt_d = rpt_q - 1'b1;
          bit_d = len_q - 1'b1;
          if (GAP == 0) begin
            d_d     = pick(pat_q, len_q - 1'b1);
            valid_d = 1'b1;
          end else begin
            state_d = GAP_S;
            gap_d   = GAP_LAST;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      GAP_S: begin
        busy_d = 1'b1;
        if (gap_q == '0) begin
          state_d = SHIFT;
          d_d     = pick(pat_q, bit_q);
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      d_d     = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      rpt_q   <= '0;
      gap_q   <= '0;
      d_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      rpt_q   <= rpt_d;
      gap_q   <= gap_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
